// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: decodes MIPS conditional branches, flags mispredicts,
// and trains a 2-bit saturating BHT plus saturating branch/mispredict counters.
module branch_resolve_unit #(
    parameter  int DATA_WIDTH = 32,
    parameter  int BHT_DEPTH  = 64,
    parameter  int STAT_W     = 16,
    localparam int IDX_W      = $clog2(BHT_DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [DATA_WIDTH-1:0] ReadData1,
    input  logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [5:0]            OpCode,
    input  logic [4:0]            Instruction_20_16,
    input  logic [IDX_W-1:0]      BrIndex,
    input  logic                  PredTaken,
    input  logic                  Flush,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  IsBranch,
    output logic                  Taken,
    output logic                  Mispredict,
    output logic                  IsLink,
    input  logic [IDX_W-1:0]      LookupIndex,
    output logic                  LookupTaken,
    output logic [STAT_W-1:0]     BranchCount,
    output logic [STAT_W-1:0]     MispredCount
);

    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] held_idx;
    logic             dec_branch;
    logic             dec_taken;
    logic             dec_link;
    logic             rs_neg;
    logic             rs_zero;
    logic             accept;
    logic             handoff;

    assign rs_neg  = ReadData1[DATA_WIDTH-1];
    assign rs_zero = (ReadData1 == '0);

    always_comb begin
        dec_branch = 1'b0;
        dec_taken  = 1'b0;
        dec_link   = 1'b0;
        case (OpCode)
            6'b000100: begin dec_branch = 1'b1; dec_taken = (ReadData1 == ReadData2); end
            6'b000101: begin dec_branch = 1'b1; dec_taken = (ReadData1 != ReadData2); end
            6'b000110: begin dec_branch = 1'b1; dec_taken = rs_neg || rs_zero;        end
            6'b000111: begin dec_branch = 1'b1; dec_taken = !rs_neg && !rs_zero;      end
            6'b000001: begin
                case (Instruction_20_16)
                    5'b00000: begin dec_branch = 1'b1; dec_taken = rs_neg;  end
                    5'b00001: begin dec_branch = 1'b1; dec_taken = !rs_neg; end
                    5'b10000: begin dec_branch = 1'b1; dec_taken = rs_neg;  dec_link = 1'b1; end
                    5'b10001: begin dec_branch = 1'b1; dec_taken = !rs_neg; dec_link = 1'b1; end
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

    assign In_Ready    = !Flush && (!Out_Valid || Out_Ready);
    assign accept      = In_Valid && In_Ready;
    assign handoff     = Out_Valid && Out_Ready && !Flush;
    // Combinational read sees the pre-update entry when it collides with a handoff.
    assign LookupTaken = bht[LookupIndex][1];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Out_Valid    <= 1'b0;
            IsBranch     <= 1'b0;
            Taken        <= 1'b0;
            Mispredict   <= 1'b0;
            IsLink       <= 1'b0;
            held_idx     <= '0;
            BranchCount  <= '0;
            MispredCount <= '0;
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else begin
            if (accept) begin
                Out_Valid  <= 1'b1;
                IsBranch   <= dec_branch;
                Taken      <= dec_taken;
                Mispredict <= dec_branch && (dec_taken != PredTaken);
                IsLink     <= dec_link;
                held_idx   <= BrIndex;
            end else if (handoff || Flush) begin
                Out_Valid <= 1'b0;
            end

            if (handoff && IsBranch) begin
                if (Taken && bht[held_idx] != 2'b11) begin
                    bht[held_idx] <= bht[held_idx] + 2'b01;
                end else if (!Taken && bht[held_idx] != 2'b00) begin
                    bht[held_idx] <= bht[held_idx] - 2'b01;
                end
                if (BranchCount != '1) begin
                    BranchCount <= BranchCount + STAT_ONE;
                end
                if (Mispredict && MispredCount != '1) begin
                    MispredCount <= MispredCount + STAT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Registered, parametrised branch resolver for the EX stage. It evaluates all MIPS conditional branches, including the REGIMM link forms. It compares the actual outcome against the fetch-time prediction and flags mispredicts. It owns a 2-bit saturating branch history table (BHT) with a combinational lookup port for fetch, trained on resolution, plus saturating branch and mispredict statistics counters.

Parameters:
DATA_WIDTH, 32, operand width in bits (>=2)
BHT_DEPTH, 64, number of 2-bit counters; power of two, >=2
IDX_W, log2(BHT_DEPTH), BHT index width (derived localparam)
STAT_W, 16, width of statistics counters

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  asynchronous, active-high reset
In_Valid  in  1  request valid
In_Ready  out  1  unit can accept request this cycle
ReadData1  in  DATA_WIDTH  rs operand
ReadData2  in  DATA_WIDTH  rt operand
OpCode  in  6  instruction [31:26]
Instruction_20_16  in  5  rt field (REGIMM selector)
BrIndex  in  IDX_W  BHT index of this branch (PC bits chosen by fetch)
PredTaken  in  1  prediction used at fetch
Flush  in  1  kill held result and block acceptance this cycle
Out_Valid  out  1  result valid
Out_Ready  in  1  consumer accepts result
IsBranch  out  1  opcode/rt decoded as a supported branch
Taken  out  1  actual outcome
Mispredict  out  1  IsBranch and (Taken != PredTaken)
IsLink  out  1  bltzal/bgezal
LookupIndex  in  IDX_W  fetch lookup index
LookupTaken  out  1  MSB of BHT[LookupIndex], combinational
BranchCount  out  STAT_W  resolved branches, saturating
MispredCount  out  STAT_W  resolved mispredicts, saturating

Behaviour:
- Decode (signed compares, DATA_WIDTH wide):
  - 000100 beq: rs==rt
  - 000101 bne: rs!=rt
  - 000110 blez: rs<=0
  - 000111 bgtz: rs>0
  - 000001 with rt=00000 bltz: rs<0
  - 000001 with rt=00001 bgez: rs>=0
  - 000001 with rt=10000 bltzal: rs<0, IsLink=1
  - 000001 with rt=10001 bgezal: rs>=0, IsLink=1
  - Any other opcode/rt: IsBranch=0, Taken=0, Mispredict=0, IsLink=0.
- Pipeline: single output register; latency 1 cycle from accept to Out_Valid.
  - Accept when In_Valid && In_Ready.
  - In_Ready = !Flush && (!Out_Valid || Out_Ready).
  - Result held stable while Out_Valid && !Out_Ready.
- Handoff: Out_Valid && Out_Ready && !Flush.
  - Only on handoff with IsBranch=1: update BHT[BrIndex] (Taken: +1 saturating at 11; not taken: -1 saturating at 00).
  - BranchCount +1 and, if Mispredict, MispredCount +1, both saturating at all-ones.
  - Non-branch handoffs change nothing.
- Flush: next cycle Out_Valid=0; the held result is discarded without BHT or stat update; no new request accepted in the Flush cycle.
- Back-to-back: a handoff and a new accept in the same cycle are allowed (full throughput).
- Lookup/update collision: when LookupIndex==BrIndex in the handoff cycle, LookupTaken shows the pre-update value.
- Reset (async, any time, including mid-transaction): Out_Valid=0, IsBranch/Taken/Mispredict/IsLink=0, all BHT entries=01 (weakly not-taken, so LookupTaken=0), BranchCount=0, MispredCount=0. The in-flight result is lost.
- Outputs other than LookupTaken are registered.

Test Plan:
- Reset, then beq rs=5 rt=5 PredTaken=0 BrIndex=3, Out_Ready=1 -> next cycle Out_Valid=1, Taken=1, Mispredict=1; after handoff BHT[3]=10, LookupTaken(3)=1, BranchCount=1, MispredCount=1.
- DATA_WIDTH=32: blez rs=0x80000000 -> Taken=1; bgtz rs=0 -> Taken=0; bgezal rs=0 -> Taken=1, IsLink=1; REGIMM rt=00010 -> IsBranch=0, counters unchanged.
- Hold Out_Ready=0 for 3 cycles with a second request pending -> In_Ready=0, outputs stable; raise Out_Ready -> first result hands off, second accepted the same cycle, result valid the next cycle.
- Flush asserted while Out_Valid=1 holding a taken bne at index 7 -> Out_Valid=0 next cycle, BHT[7] stays 01, BranchCount unchanged, In_Ready=0 during the Flush cycle.
- Four taken branches at index 0, then two not-taken -> BHT[0] sequence 10, 11, 11, 11, 10, 01; LookupTaken(0) in the collision cycle shows the pre-update value.
- STAT_W=2: five mispredicting branches -> BranchCount and MispredCount saturate at 3. Asserting Rst mid-hold -> Out_Valid=0 immediately, counters cleared.
